// File: rtl/dtcm_ldst_responder.sv
// dtcm_ldst_responder: data tightly-coupled memory on the slave end of the
// core load/store channel. One request per handshake; every request (load or
// store) gets exactly one response, issued the cycle after the handshake.
//
// Optional build macro: DTCM_MISALIGN_ERR_EN adds rsp_err. It suppresses
// misaligned stores and flags misaligned stores and out-of-range accesses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_vld/req_rdy   request handshake (rdy is combinational on rsp_rdy)
//   req_addr          byte address
//   req_st            1 = store, 0 = load
//   req_data          store data, LSB-justified
//   req_strobe        byte strobes, LSB-justified (0001/0011/1111)
//   rsp_vld/rsp_rdy   response handshake
//   rsp_data          load data shifted to LSBs; 0 for stores
//   rsp_err           error flag, valid with rsp_vld (DTCM_MISALIGN_ERR_EN only)
module dtcm_ldst_responder #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [31:0] req_addr,
  input  logic        req_st,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_strobe,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_data
`ifdef DTCM_MISALIGN_ERR_EN
  ,
  output logic        rsp_err
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RSP  = 1'b1;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic          req_hsk;
  logic          rsp_hsk;

  logic [1:0]    off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic [3:0]    lane_mask;
  logic [31:0]   wdata;
  logic          wr_en;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_word_q;
  logic [1:0]    off_q;

  // Handshakes and channel status
  assign rsp_vld = (state_q == ST_RSP);
  assign req_rdy = (state_q == ST_IDLE) | ((state_q == ST_RSP) & rsp_rdy);
  assign req_hsk = req_vld & req_rdy;
  assign rsp_hsk = rsp_vld & rsp_rdy;

  // Address decode
  assign off       = req_addr[1:0];
  assign idx       = req_addr[AW+1:2];
  assign in_range  = (req_addr[31:AW+2] == '0);

  // Lanes shifted past byte 3 fall off the top of the 4-bit mask
  assign lane_mask = 4'(req_strobe << off);
  assign wdata     = 32'(req_data << {off, 3'b000});

`ifdef DTCM_MISALIGN_ERR_EN
  logic misalign;
  logic req_err;
  logic err_q;

  assign misalign = ((req_strobe == 4'b0011) & off[0]) |
                    ((req_strobe == 4'b1111) & (off != 2'd0)) |
                    ((req_strobe != 4'b0001) & (req_strobe != 4'b0011) &
                     (req_strobe != 4'b1111));
  assign req_err  = ~in_range | (req_st & misalign);
  assign wr_en    = req_hsk & ~rst & req_st & in_range & ~misalign;

  // Error flag captured alongside the response payload
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (req_hsk) begin
      err_q <= req_err;
    end
  end

  assign rsp_err = err_q;
`else
  assign wr_en = req_hsk & ~rst & req_st & in_range;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a request accepted while the response drains keeps RSP
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_hsk) state_d = ST_RSP;
      ST_RSP:  if (rsp_hsk & ~req_hsk) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte-lane write into the array; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Response payload; only reloaded on a request handshake so it holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word_q <= '0;
      off_q     <= '0;
    end else if (req_hsk) begin
      rd_word_q <= (req_st | ~in_range) ? 32'd0 : mem[idx];
      off_q     <= req_st ? 2'd0 : off;
    end
  end

  assign rsp_data = rd_word_q >> {off_q, 3'b000};

endmodule

// File: tb/tb_dtcm_ldst_responder.sv
// Randomized and directed bench for dtcm_ldst_responder with a byte-level
// reference model and an expected-response queue.
module tb_dtcm_ldst_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [31:0] req_addr = '0;
  logic        req_st = 1'b0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_strobe = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rsp_data;
`ifdef DTCM_MISALIGN_ERR_EN
  logic        rsp_err;
`endif

  always #5 clk = ~clk;

  dtcm_ldst_responder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_addr   (req_addr),
    .req_st     (req_st),
    .req_data   (req_data),
    .req_strobe (req_strobe),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_data   (rsp_data)
`ifdef DTCM_MISALIGN_ERR_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] q_data [$];
  logic        q_err [$];
  logic [31:0] last_data;
  logic        last_err;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit aligned(input logic [3:0] b, input int off);
    return (b == 4'b0001) || (b == 4'b0011 && off % 2 == 0) || (b == 4'b1111 && off == 0);
  endfunction

  // Byte-level behaviour of one accepted request; queues its expected response
  task automatic model_req(input logic st, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b);
    int          off  = int'(a % 4);
    int unsigned widx = a / 4;
    bit          inr  = (widx < DEPTH);
    logic [31:0] rd;
    logic        e    = 1'b0;
    bit          wr_ok;
`ifdef DTCM_MISALIGN_ERR_EN
    if (!inr) e = 1'b1;
    if (st && !aligned(b, off)) e = 1'b1;
`endif
    wr_ok = st && inr && !e;
    if (wr_ok) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (b[lane] && (lane + off) < 4) mdl[widx][8*(lane+off) +: 8] = d[8*lane +: 8];
      end
    end
    if (st || !inr) rd = 32'd0;
    else rd = mdl[widx] >> (8 * off);
    q_data.push_back(rd);
    q_err.push_back(e);
  endtask

  // One clock: drive at negedge, sample just after, check, update model
  task automatic cycle(input logic v, input logic s, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic rr, output logic hsk);
    logic exp_vld;
    @(negedge clk);
    req_vld = v; req_st = s; req_addr = a; req_data = d; req_strobe = b; rsp_rdy = rr;
    #1;
    exp_vld = (q_data.size() != 0);
    chk_eq("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
    chk_eq("req_rdy", 32'(req_rdy), 32'(!exp_vld || rr));
    if (exp_vld) begin
      chk_eq("rsp_data", rsp_data, q_data[0]);
`ifdef DTCM_MISALIGN_ERR_EN
      chk_eq("rsp_err", 32'(rsp_err), 32'(q_err[0]));
`endif
    end
    hsk = v && req_rdy;
    if (exp_vld && rr) begin
      last_data = rsp_data;
`ifdef DTCM_MISALIGN_ERR_EN
      last_err = rsp_err;
`else
      last_err = 1'b0;
`endif
      void'(q_data.pop_front());
      void'(q_err.pop_front());
    end
    if (hsk) model_req(s, a, d, b);
  endtask

  task automatic send(input logic s, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b);
    logic h = 1'b0;
    for (int i = 0; i < 20 && !h; i++) cycle(1'b1, s, a, d, b, 1'b1, h);
    chk_eq("send_hsk", 32'(h), 32'd1);
  endtask

  task automatic idle(input logic rr);
    logic h;
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, rr, h);
  endtask

  initial begin
    logic        h;
    logic [31:0] a, d;
    logic [3:0]  b;
    int          sel;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk_eq("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk_eq("rst_rsp_data", rsp_data, 32'd0);
`ifdef DTCM_MISALIGN_ERR_EN
    chk_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Give the first 16 words known contents
    for (int i = 0; i < 16; i++) send(1'b1, 32'(4 * i), $urandom, 4'b1111);
    idle(1'b1);

    // Store word then load it back-to-back
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    send(1'b0, 32'h10, 32'd0, 4'b1111);
    chk_eq("sw_rsp_data", last_data, 32'd0);
    idle(1'b1);
    chk_eq("lw_deadbeef", last_data, 32'hDEADBEEF);

    // Byte store into lane 3, then word and halfword-offset loads
    send(1'b1, 32'h13, 32'h000000AA, 4'b0001);
    idle(1'b1);
    send(1'b0, 32'h10, 32'd0, 4'b0000);
    idle(1'b1);
    chk_eq("lw_after_sb", last_data, 32'hAAADBEEF);
    send(1'b0, 32'h12, 32'd0, 4'b0000);
    idle(1'b1);
    chk_eq("lw_off2", last_data, 32'h0000AAAD);

    // Response stall: data held, requests refused
    send(1'b0, 32'h10, 32'd0, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h4, 32'd0, 4'b1111, 1'b0, h);
      chk_eq("stall_no_hsk", 32'(h), 32'd0);
      chk_eq("stall_data", rsp_data, 32'hAAADBEEF);
    end
    idle(1'b1);
    chk_eq("stall_release", last_data, 32'hAAADBEEF);
    idle(1'b1);

    // Back-to-back stream of stores then loads
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 32'(4 * i), $urandom, 4'b1111, 1'b1, h);
      chk_eq("stream_st_hsk", 32'(h), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'(4 * i), 32'd0, 4'b1111, 1'b1, h);
      chk_eq("stream_ld_hsk", 32'(h), 32'd1);
    end
    idle(1'b1);
    idle(1'b1);

    // Out-of-range load and misaligned halfword store
    send(1'b0, 32'h0010_0000, 32'd0, 4'b1111);
    idle(1'b1);
    chk_eq("oor_data", last_data, 32'd0);
`ifdef DTCM_MISALIGN_ERR_EN
    chk_eq("oor_err", 32'(last_err), 32'd1);
`endif
    send(1'b1, 32'h21, 32'h0000_1234, 4'b0011);
    idle(1'b1);
`ifdef DTCM_MISALIGN_ERR_EN
    chk_eq("sh_misalign_err", 32'(last_err), 32'd1);
`endif
    send(1'b0, 32'h20, 32'd0, 4'b1111);
    idle(1'b1);

    // Reset while a response is stalled
    send(1'b0, 32'h10, 32'd0, 4'b1111);
    idle(1'b0);
    @(negedge clk);
    req_vld = 1'b0; rsp_rdy = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_data.delete();
    q_err.delete();
    #1;
    chk_eq("rst_rsp_vld_drop", 32'(rsp_vld), 32'd0);
    chk_eq("rst_req_rdy_back", 32'(req_rdy), 32'd1);
    send(1'b0, 32'h10, 32'd0, 4'b1111);
    idle(1'b1);
    chk_eq("rst_mem_kept", last_data, 32'hAAADBEEF);

    // Randomized traffic against the model
    repeat (600) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      else if (sel == 1) a = $urandom | 32'h8000_0000;
      else a = 32'($urandom_range(0, 63));
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 4'($urandom);
        1, 2:    b = 4'b0001;
        3, 4:    b = 4'b0011;
        default: b = 4'b1111;
      endcase
      d = $urandom;
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), a, d, b,
            1'($urandom_range(0, 3) != 0), h);
    end

    // Drain with a bounded budget
    for (int i = 0; i < 10 && q_data.size() != 0; i++) idle(1'b1);
    chk_eq("drain_empty", 32'(q_data.size()), 32'd0);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
